// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage buffers: NOP encoding,
// occupancy/state encoding and per-stage payload widths.
package pipe_pkg;

    localparam logic [31:0] RV32_NOP = 32'h00000013;

    // State encoding doubles as the COUNT output value.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } buf_state_e;

    // IF/ID payload is {PC_PLUS_FOUR, PC, INSTRUCTION}.
    localparam int unsigned IF_ID_W = 96;

endpackage

// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer.
// The main register drives DATA_OUT; the skid register catches one payload
// during a downstream stall so that READY_OUT can stay fully registered.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int unsigned                DATA_WIDTH   = IF_ID_W,
    parameter logic [DATA_WIDTH-1:0]      BUBBLE_VALUE = DATA_WIDTH'(RV32_NOP)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic                  VALID_IN,
    output logic                  READY_OUT,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic                  VALID_OUT,
    input  logic                  READY_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    input  logic                  FLUSH,
    output logic [1:0]            COUNT
);

    buf_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] main_q, main_d;
    logic [DATA_WIDTH-1:0] skid_q, skid_d;
    logic                  ready_q, ready_d;
    logic                  accept;
    logic                  drain;

    assign VALID_OUT = (state_q != ST_EMPTY);
    assign READY_OUT = ready_q;
    assign DATA_OUT  = main_q;
    assign COUNT     = state_q;

    // Next-state and storage update; flush overrides every transition.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        accept  = VALID_IN & ready_q & ~FLUSH;
        drain   = VALID_OUT & READY_IN;

        if (FLUSH) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE_VALUE;
            skid_d  = BUBBLE_VALUE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d = ST_ONE;
                        main_d  = DATA_IN;
                    end
                end
                ST_ONE: begin
                    if (accept && drain) begin
                        main_d = DATA_IN;
                    end else if (accept) begin
                        state_d = ST_FULL;
                        skid_d  = DATA_IN;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                        main_d  = BUBBLE_VALUE;
                    end
                end
                ST_FULL: begin
                    // ready_q is low here, so only a drain can move us.
                    if (drain) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE_VALUE;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE_VALUE;
                    skid_d  = BUBBLE_VALUE;
                end
            endcase
        end

        ready_d = (state_d != ST_FULL);
    end

    // State and payload registers with asynchronous reset to the bubble.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE_VALUE;
            skid_q  <= BUBBLE_VALUE;
            ready_q <= 1'b1;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            ready_q <= ready_d;
        end
    end

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Self-checking bench for pipe_stage_buf: directed scenarios followed by
// randomized handshake traffic, all compared against a 2-deep FIFO model.
module tb_pipe_stage_buf;

    localparam int unsigned W = 96;
    localparam logic [W-1:0] BUBBLE = {64'd0, 32'h00000013};

    logic         clk;
    logic         rst;
    logic         valid_in;
    logic         ready_out;
    logic [W-1:0] data_in;
    logic         valid_out;
    logic         ready_in;
    logic [W-1:0] data_out;
    logic         flush;
    logic [1:0]   count;

    int unsigned vectors = 0;
    int unsigned errors  = 0;

    // Reference model: the stage is a FIFO of at most two payloads.
    logic [W-1:0] model_q[$];

    pipe_stage_buf #(
        .DATA_WIDTH   (W),
        .BUBBLE_VALUE (BUBBLE)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .VALID_IN  (valid_in),
        .READY_OUT (ready_out),
        .DATA_IN   (data_in),
        .VALID_OUT (valid_out),
        .READY_IN  (ready_in),
        .DATA_OUT  (data_out),
        .FLUSH     (flush),
        .COUNT     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Compare every output against what the FIFO model implies.
    task automatic check_all(input string tag);
        logic [W-1:0] exp_data;
        int unsigned  n;
        n        = model_q.size();
        exp_data = (n > 0) ? model_q[0] : BUBBLE;
        check({tag, ".valid"}, W'(valid_out), W'(n > 0));
        check({tag, ".ready"}, W'(ready_out), W'(n < 2));
        check({tag, ".count"}, W'(count), W'(n));
        check({tag, ".data"}, data_out, exp_data);
    endtask

    // One clock of stimulus; model advances using pre-edge occupancy.
    task automatic step(input string tag, input logic v, input logic [W-1:0] d,
                        input logic r, input logic f);
        logic acc;
        logic drn;
        valid_in = v;
        data_in  = d;
        ready_in = r;
        flush    = f;
        acc = v && (model_q.size() < 2) && !f;
        drn = (model_q.size() > 0) && r;
        @(posedge clk);
        if (f) begin
            model_q.delete();
        end else begin
            if (drn) void'(model_q.pop_front());
            if (acc) model_q.push_back(d);
        end
        #1;
        check_all(tag);
    endtask

    initial begin
        valid_in = 1'b0;
        data_in  = '0;
        ready_in = 1'b0;
        flush    = 1'b0;
        rst      = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Some traffic, then reset asserted asynchronously mid-stream.
        step("pre0", 1'b1, W'(32'h11), 1'b0, 1'b0);
        step("pre1", 1'b1, W'(32'h12), 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        model_q.delete();
        #1;
        check_all("async_rst");
        @(negedge clk);
        rst = 1'b0;

        // Streaming at full throughput.
        step("strm_a0", 1'b1, W'(32'hA0), 1'b1, 1'b0);
        step("strm_a1", 1'b1, W'(32'hA1), 1'b1, 1'b0);
        step("strm_a2", 1'b1, W'(32'hA2), 1'b1, 1'b0);
        step("strm_end", 1'b0, W'(32'h0), 1'b1, 1'b0);

        // Single-cycle stall while B1 is on DATA_OUT.
        step("stall_b0", 1'b1, W'(32'hB0), 1'b1, 1'b0);
        step("stall_b1", 1'b1, W'(32'hB1), 1'b1, 1'b0);
        step("stall_b2", 1'b1, W'(32'hB2), 1'b0, 1'b0);
        step("stall_d1", 1'b0, W'(32'h0), 1'b1, 1'b0);
        step("stall_d2", 1'b0, W'(32'h0), 1'b1, 1'b0);

        // Long stall: only two payloads absorbed, output held.
        for (int i = 0; i < 5; i++) begin
            step("long", 1'b1, W'(32'hD0 + i), 1'b0, 1'b0);
        end

        // Flush in FULL with a live incoming payload.
        step("flush_full", 1'b1, W'(32'hC5), 1'b1, 1'b1);
        step("after_flush", 1'b0, W'(32'hC6), 1'b1, 1'b0);

        // Randomized handshake with occasional flushes.
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] d;
            d = {$urandom(), $urandom(), $urandom()};
            step("rand", 1'($urandom_range(0, 3) != 0), d,
                 1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 63) == 0));
        end

        // Drain whatever is left.
        step("final0", 1'b0, W'(0), 1'b1, 1'b0);
        step("final1", 1'b0, W'(0), 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
